// File: rtl/max_err_pkg.sv
// Shared types and width helpers for the approximate-vs-exact max-partition error monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package max_err_pkg;

    // Window control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default output-vector width of the monitored 10-in/5-out partition.
    localparam int W_DATA_DEF = 5;
    // Default window length and counter width.
    localparam int W_CNT_DEF  = 16;

    // Bits needed to hold a per-pair Hamming distance (0..wd).
    function automatic int hd_w(input int wd);
        return $clog2(wd + 1);
    endfunction

    // hd_sum width: wide enough for wd * (2^wc - 1) so the sum never wraps.
    function automatic int hd_sum_w(input int wc, input int wd);
        return wc + hd_w(wd);
    endfunction

endpackage

// File: rtl/max_err_calc.sv
// Per-pair error metrics: mismatch flag, Hamming distance and absolute difference.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results follow the inputs every cycle.
module max_err_calc
    import max_err_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF
) (
    input  logic [W_DATA-1:0]         approx,
    input  logic [W_DATA-1:0]         exact,
    output logic                      mismatch,
    output logic [hd_w(W_DATA)-1:0]   hd,
    output logic [W_DATA-1:0]         abs_err
);

    localparam int HD_W = hd_w(W_DATA);

    logic [W_DATA-1:0] diff_bits;
    logic signed [W_DATA:0] diff;

    assign diff_bits = approx ^ exact;
    assign mismatch  = |diff_bits;

    // Population count of the differing bits.
    always_comb begin
        hd = '0;
        for (int i = 0; i < W_DATA; i++) begin
            hd = hd + HD_W'(diff_bits[i]);
        end
    end

    // Signed difference one bit wider than the data, then magnitude truncated back to W_DATA.
    always_comb begin
        diff    = $signed({1'b0, approx}) - $signed({1'b0, exact});
        abs_err = diff[W_DATA] ? W_DATA'(-diff) : W_DATA'(diff);
    end

endmodule

// File: rtl/max_err_monitor.sv
// Windowed error statistics between approximate and exact partition outputs.
// Latency: statistics update one cycle after each accepted pair; done the cycle after the last pair.
// Backpressure: in_ready is high only while a window is running; pairs are otherwise refused.
module max_err_monitor
    import max_err_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_CNT  = W_CNT_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [W_CNT-1:0]                   win_len,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [W_DATA-1:0]                  approx,
    input  logic [W_DATA-1:0]                  exact,
    output logic                               busy,
    output logic                               done,
    output logic [W_CNT-1:0]                   sample_cnt,
    output logic [W_CNT-1:0]                   err_cnt,
    output logic [hd_sum_w(W_CNT, W_DATA)-1:0] hd_sum,
    output logic [W_DATA-1:0]                  max_abs_err
);

    localparam int HD_W  = hd_w(W_DATA);
    localparam int HSUMW = hd_sum_w(W_CNT, W_DATA);

    state_t state, state_nxt;

    logic [W_CNT-1:0]  win_lat;
    logic              xfer;
    logic              start_acc;
    logic              last_xfer;
    logic              mismatch;
    logic [HD_W-1:0]   hd;
    logic [W_DATA-1:0] abs_err;

    max_err_calc #(
        .W_DATA (W_DATA)
    ) u_calc (
        .approx   (approx),
        .exact    (exact),
        .mismatch (mismatch),
        .hd       (hd),
        .abs_err  (abs_err)
    );

    assign xfer      = in_valid & in_ready;
    assign start_acc = start & (state != RUN);
    assign last_xfer = xfer & ((sample_cnt + W_CNT'(1)) == win_lat);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start opens a window (or completes an empty one at once); last pair closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (win_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        in_ready = (state == RUN);
    end

    // Window length latch and accumulators: cleared on an accepted start, updated per transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_lat     <= '0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            hd_sum      <= '0;
            max_abs_err <= '0;
        end else if (start_acc) begin
            win_lat     <= win_len;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            hd_sum      <= '0;
            max_abs_err <= '0;
        end else if (xfer) begin
            sample_cnt <= sample_cnt + W_CNT'(1);
            if (mismatch) begin
                err_cnt <= err_cnt + W_CNT'(1);
            end
            hd_sum <= hd_sum + HSUMW'(hd);
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end
        end
    end

endmodule

// File: tb/tb_max_err_monitor.sv
// Directed and randomised checks of the window error monitor.
// Latency: inputs applied #1 after a rising edge, outputs checked #1 after the next one.
// Backpressure: exercised through win_len exhaustion and gapped in_valid.
module tb_max_err_monitor;

    localparam int W_DATA = 5;
    localparam int W_CNT  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [W_CNT-1:0]  win_len;
    logic              in_valid;
    logic              in_ready;
    logic [W_DATA-1:0] approx;
    logic [W_DATA-1:0] exact;
    logic              busy;
    logic              done;
    logic [W_CNT-1:0]  sample_cnt;
    logic [W_CNT-1:0]  err_cnt;
    logic [W_CNT+2:0]  hd_sum;
    logic [W_DATA-1:0] max_abs_err;

    int vectors;
    int miscompares;

    max_err_monitor #(
        .W_DATA (W_DATA),
        .W_CNT  (W_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .win_len     (win_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .approx      (approx),
        .exact       (exact),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .hd_sum      (hd_sum),
        .max_abs_err (max_abs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag, input int sc, input int ec, input int hs, input int mx);
        chk({tag, ".sample_cnt"}, 32'(sample_cnt), sc);
        chk({tag, ".err_cnt"}, 32'(err_cnt), ec);
        chk({tag, ".hd_sum"}, 32'(hd_sum), hs);
        chk({tag, ".max_abs_err"}, 32'(max_abs_err), mx);
    endtask

    task automatic chk_flags(input string tag, input int b, input int d, input int r);
        chk({tag, ".busy"}, 32'(busy), b);
        chk({tag, ".done"}, 32'(done), d);
        chk({tag, ".in_ready"}, 32'(in_ready), r);
    endtask

    task automatic open_win(input int len);
        start   = 1'b1;
        win_len = W_CNT'(len);
        step();
        start   = 1'b0;
        win_len = '0;
    endtask

    task automatic send(input int a, input int e);
        in_valid = 1'b1;
        approx   = W_DATA'(a);
        exact    = W_DATA'(e);
        step();
        in_valid = 1'b0;
    endtask

    int m_sc, m_ec, m_hs, m_mx, d, sent, cycles;
    logic [W_DATA-1:0] ra, re;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        win_len  = '0;
        in_valid = 1'b0;
        approx   = '0;
        exact    = '0;

        // Reset state.
        step();
        step();
        chk_flags("rst", 0, 0, 0);
        chk_stats("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk_flags("post_rst_idle", 0, 0, 0);

        // Basic window of 4 back-to-back pairs.
        open_win(4);
        chk_flags("w4_open", 1, 0, 1);
        chk_stats("w4_open", 0, 0, 0, 0);
        send(5, 5);
        chk_stats("w4_p1", 1, 0, 0, 0);
        send(5, 4);
        chk_stats("w4_p2", 2, 1, 1, 1);
        send(31, 0);
        chk_stats("w4_p3", 3, 2, 6, 31);
        chk_flags("w4_p3", 1, 0, 1);
        send(0, 1);
        chk_stats("w4_p4", 4, 3, 7, 31);
        chk_flags("w4_p4", 0, 1, 0);
        // Results held while DONE, extra valid pairs ignored.
        send(3, 28);
        step();
        chk_stats("w4_hold", 4, 3, 7, 31);
        chk_flags("w4_hold", 0, 1, 0);

        // Zero-length window completes at once with cleared statistics.
        open_win(0);
        chk_flags("w0", 0, 1, 0);
        chk_stats("w0", 0, 0, 0, 0);
        send(9, 2);
        chk_flags("w0_later", 0, 1, 0);
        chk_stats("w0_later", 0, 0, 0, 0);

        // win_len = 3 with gapped in_valid.
        open_win(3);
        send(1, 2);
        chk_stats("w3_t1", 1, 1, 2, 1);
        step();
        chk_stats("w3_gap1", 1, 1, 2, 1);
        send(3, 3);
        chk_stats("w3_t2", 2, 1, 2, 1);
        step();
        chk("w3_ready_before_last", 32'(in_ready), 1);
        send(16, 15);
        chk_stats("w3_t3", 3, 2, 7, 1);
        chk_flags("w3_t3", 0, 1, 0);
        send(31, 0);
        chk_stats("w3_fourth", 3, 2, 7, 1);

        // Start pulsed mid-window is ignored.
        open_win(5);
        send(2, 7);
        send(10, 10);
        chk_stats("w5_p2", 2, 1, 2, 5);
        start   = 1'b1;
        win_len = W_CNT'(2);
        send(8, 1);
        start   = 1'b0;
        win_len = '0;
        chk_stats("w5_p3", 3, 2, 4, 7);
        chk_flags("w5_p3", 1, 0, 1);
        send(12, 12);
        chk_flags("w5_p4", 1, 0, 1);
        send(20, 4);
        chk_stats("w5_p5", 5, 3, 5, 16);
        chk_flags("w5_p5", 0, 1, 0);

        // Asynchronous reset mid-window.
        open_win(4);
        send(1, 0);
        send(2, 0);
        chk_stats("rw_p2", 2, 2, 2, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("rw_async", 0, 0, 0);
        chk_stats("rw_async", 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        step();
        chk_flags("rw_idle", 0, 0, 0);
        open_win(1);
        send(7, 3);
        chk_stats("rw_new", 1, 1, 1, 4);
        chk_flags("rw_new", 0, 1, 0);

        // Random 1000-pair window against an arithmetic reference.
        m_sc = 0; m_ec = 0; m_hs = 0; m_mx = 0;
        sent = 0; cycles = 0;
        open_win(1000);
        while (sent < 1000 && cycles < 5000) begin
            cycles++;
            if (sent == 500) begin
                ra = 5'd31;
                re = 5'd31;
            end else begin
                ra = W_DATA'($urandom_range(0, 31));
                re = W_DATA'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 3) == 0 && sent != 500) begin
                in_valid = 1'b0;
                approx   = ra;
                exact    = re;
                step();
            end else begin
                send(int'(ra), int'(re));
                sent++;
                m_sc++;
                if (ra != re) m_ec++;
                m_hs += $countones(ra ^ re);
                d = int'(ra) - int'(re);
                if (d < 0) d = -d;
                if (d > m_mx) m_mx = d;
            end
        end
        chk("rnd_all_sent", sent, 1000);
        chk_stats("rnd", m_sc, m_ec, m_hs, m_mx);
        chk_flags("rnd", 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/max_err_monitor.md
MAX_ERR_MONITOR -- requirements
Module: max_err_monitor

Interface
REQ-001 Parameters: W_DATA, default 5, output-vector width of the monitored 10-in/5-out max partition; W_CNT, default 16, window and counter width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that opens a new measurement window.
REQ-006 win_len  input  W_CNT  number of vector pairs per window; sampled only on an accepted start.
REQ-007 in_valid  input  1  approx/exact pair is present this cycle.
REQ-008 in_ready  output  1  monitor accepts a pair this cycle.
REQ-009 approx  input  W_DATA  po4..po0 from the approximate partition (po4 = MSB).
REQ-010 exact  input  W_DATA  po4..po0 from the exact partition for the same pi vector.
REQ-011 busy  output  1  window in progress.
REQ-012 done  output  1  window complete; results valid and held.
REQ-013 sample_cnt  output  W_CNT  pairs accepted in the current window.
REQ-014 err_cnt  output  W_CNT  accepted pairs with approx != exact.
REQ-015 hd_sum  output  W_CNT+3  sum of per-pair Hamming distances.
REQ-016 max_abs_err  output  W_DATA  largest |approx - exact| in the window, unsigned.

Function
REQ-017 FSM states are IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE); in_ready = busy.
REQ-018 IDLE or DONE with start = 1 and win_len != 0: clear all statistics, latch win_len, and enter RUN on the next edge.
REQ-019 IDLE or DONE with start = 1 and win_len == 0: clear all statistics and enter DONE.
REQ-020 start in RUN is ignored; the window continues unchanged.
REQ-021 Handshake: transfer occurs when in_valid & in_ready; in_valid without in_ready causes no change.
REQ-022 On transfer:
- sample_cnt +1;
- err_cnt +1 if approx != exact;
- hd_sum += popcount(approx ^ exact);
- max_abs_err = max(max_abs_err, |approx - exact|).
All four updates are visible one cycle after the transfer.
REQ-023 The transfer that brings sample_cnt to the latched win_len moves the FSM to DONE on the same edge; in_ready is 0 from the next cycle; no further pairs are accepted.
REQ-024 Counters never wrap: sample_cnt is bounded by win_len and hd_sum width covers W_DATA * (2^W_CNT - 1).
REQ-025 DONE holds all statistics stable until the next accepted start.
REQ-026 |approx - exact| is computed at W_DATA+1 bits signed, then magnitude truncated to W_DATA.

Reset
REQ-027 rst_n low: state = IDLE; busy, done and in_ready = 0; sample_cnt, err_cnt, hd_sum, max_abs_err and the latched win_len = 0, asynchronously.
REQ-028 Reset asserted mid-RUN abandons the window; after release the block idles until start.
REQ-029 Reset release is synchronised externally; the block performs no action in the first cycle after release beyond honouring start.

Structure
REQ-030 Shared package max_err_pkg holds the state enum (IDLE, RUN, DONE), the W_DATA and W_CNT defaults, and the hd_sum width derivation.
REQ-031 One combinational sub-module max_err_calc takes approx and exact and returns mismatch, Hamming distance (3 bits) and abs error (W_DATA bits).
REQ-032 The top level contains only the FSM, the win_len latch and the accumulators.

Verification
REQ-033 Reset, then start with win_len = 4; send pairs (5,5), (5,4), (31,0), (0,1) back-to-back -> done after the 4th pair; sample_cnt = 4, err_cnt = 3, hd_sum = 0+1+5+1 = 7, max_abs_err = 31.
REQ-034 Start with win_len = 0 -> done = 1 the next cycle, all statistics 0, in_ready never high.
REQ-035 win_len = 3 with in_valid toggled 1,0,1,0,1 -> exactly 3 transfers; in_ready drops the cycle after the 3rd; a 4th valid pair is not counted.
REQ-036 Start pulsed in RUN after 2 of 5 pairs -> ignored; the window completes at 5 with cumulative statistics.
REQ-037 rst_n asserted after 2 of 4 pairs -> all outputs 0 immediately; a new start with win_len = 1 and pair (7,3) -> err_cnt = 1, hd_sum = 1, max_abs_err = 4.
REQ-038 Random 1000-pair window (win_len = 1000) against a reference model, including the pair 31 vs 31 (error 0) -> all four statistics match exactly.
